// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port of the byte-RAM arbiter.
//   req    requester -> arbiter  transaction request, held until ack
//   we     requester -> arbiter  1 = write, 0 = read; stable while req
//   addr   requester -> arbiter  byte address; stable while req
//   wdata  requester -> arbiter  write data; stable while req
//   rdata  arbiter -> requester  read data, valid while ack=1, held until next read
//   ack    arbiter -> requester  one-cycle completion pulse
// Modports: master (requester side), slave (arbiter side).
interface mem_arbiter_if #(
  parameter int addr_width = 9
) ();
  logic                  req;
  logic                  we;
  logic [addr_width-1:0] addr;
  logic [7:0]            wdata;
  logic [7:0]            rdata;
  logic                  ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide block RAM between port0 (cpu) and port1
// (serial loader / debug monitor). One read or write transaction is in flight
// at a time; each completes with a one-cycle ack on its port.
// RAM model assumed: synchronous write on ram_write, registered read (data
// valid one cycle after ram_raddr is driven).
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   port0, port1         requester interfaces (mem_arbiter_if.slave)
//   ram_raddr/ram_waddr  RAM read/write addresses, held when idle
//   ram_data_in          RAM write data
//   ram_write            one-cycle RAM write strobe
//   ram_data_out         RAM registered read data
//   grant                port owning the current or last transaction
//   busy                 1 whenever the FSM is not IDLE
//
// Configuration: define MEM_ARB_FIXED_PRIO_EN for fixed priority (port0 wins
// every tie). Default build is round-robin.
module mem_arbiter #(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_arbiter_if.slave          port0,
  mem_arbiter_if.slave          port1,
  output logic [addr_width-1:0] ram_raddr,
  output logic [addr_width-1:0] ram_waddr,
  output logic [7:0]            ram_data_in,
  output logic                  ram_write,
  input  logic [7:0]            ram_data_out,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR, DONE} state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [7:0]            rdata0_q, rdata0_d;
  logic [7:0]            rdata1_q, rdata1_d;
  logic [addr_width-1:0] raddr_q, raddr_d;
  logic [addr_width-1:0] waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  ram_write_q, ram_write_d;
  logic                  busy_q, busy_d;

  logic                  win;
  logic                  win_we;
  logic [addr_width-1:0] win_addr;
  logic [7:0]            win_wdata;

  // Winner selection, only consulted in IDLE.
  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    win = port0.req ? 1'b0 : 1'b1;
`else
    // On a tie the port that did not go last wins; otherwise the lone requester.
    win = (port0.req && port1.req) ? ~last_q : port1.req;
`endif
    win_we    = win ? port1.we    : port0.we;
    win_addr  = win ? port1.addr  : port0.addr;
    win_wdata = win ? port1.wdata : port0.wdata;
  end

  always_comb begin
    // NOTE: every signal gets a default (hold) first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    ack0_d      = ack0_q;
    ack1_d      = ack1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    ram_write_d = ram_write_q;

    unique case (state_q)
      IDLE: begin
        if (port0.req || port1.req) begin
          grant_d = win;
          last_d  = win;
          if (win_we) begin
            waddr_d     = win_addr;
            wdata_d     = win_wdata;
            ram_write_d = 1'b1;
            state_d     = WR;
          end else begin
            raddr_d = win_addr;
            state_d = RD_WAIT;
          end
        end
      end
      // RAM registers the read address at the end of this cycle.
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        if (grant_q) begin
          rdata1_d = ram_data_out;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = ram_data_out;
          ack0_d   = 1'b1;
        end
        state_d = DONE;
      end
      WR: begin
        ram_write_d = 1'b0;
        ack0_d      = ~grant_q;
        ack1_d      = grant_q;
        state_d     = DONE;
      end
      // Ack is visible here; returning through IDLE only after the requester
      // has had its edge to drop req prevents a re-grant on a stale request.
      DONE: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;  // port0 wins the first tie
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ram_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ram_write_q <= ram_write_d;
      busy_q      <= busy_d;
    end
  end

  assign port0.ack   = ack0_q;
  assign port1.ack   = ack1_q;
  assign port0.rdata = rdata0_q;
  assign port1.rdata = rdata1_q;
  assign ram_raddr   = raddr_q;
  assign ram_waddr   = waddr_q;
  assign ram_data_in = wdata_q;
  assign ram_write   = ram_write_q;
  assign grant       = grant_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural
// block RAM, a reference memory and per-port scoreboards of expected acks.
module tb_mem_arbiter;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [7:0]    ram_data_in, ram_data_out;
  logic          ram_write, grant, busy;

  always #5 clk = ~clk;

  mem_arbiter_if #(.addr_width(AW)) p0_if ();
  mem_arbiter_if #(.addr_width(AW)) p1_if ();

  mem_arbiter #(.addr_width(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .port0        (p0_if),
    .port1        (p1_if),
    .ram_raddr    (ram_raddr),
    .ram_waddr    (ram_waddr),
    .ram_data_in  (ram_data_in),
    .ram_write    (ram_write),
    .ram_data_out (ram_data_out),
    .grant        (grant),
    .busy         (busy)
  );

  // Behavioural block RAM: synchronous write, registered read.
  logic [7:0] ram     [512];
  logic [7:0] ref_mem [512];
  always @(posedge clk) begin
    if (ram_write) ram[ram_waddr] <= ram_data_in;
    ram_data_out <= ram[ram_raddr];
  end

  typedef struct {
    bit         we;
    logic [8:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       exp_q [2][$];
  int         checks   = 0;
  int         failures = 0;
  int         ack_cnt [2] = '{0, 0};
  logic [7:0] rd_track [2];
  logic [8:0] waddr_track;
  logic       prev_write;
  logic       m_ack;
  logic [7:0] m_rd, m_rd_other;
  txn_t       m_e;

  // Scoreboard monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      rd_track[0] = '0;
      rd_track[1] = '0;
      waddr_track = '0;
      prev_write  = 1'b0;
    end else begin
      if (ram_write) begin
        checks++;
        if (prev_write) begin
          failures++;
          $display("FAIL ram_write_pulse: got high two cycles in a row, required one cycle");
        end
      end
      prev_write = ram_write;
      if (p0_if.ack || p1_if.ack) begin
        checks++;
        if (p0_if.ack && p1_if.ack) begin
          failures++;
          $display("FAIL dual_ack: got ack0=1 ack1=1, required at most one");
        end
      end
      for (int p = 0; p < 2; p++) begin
        m_ack      = (p == 0) ? p0_if.ack   : p1_if.ack;
        m_rd       = (p == 0) ? p0_if.rdata : p1_if.rdata;
        m_rd_other = (p == 0) ? p1_if.rdata : p0_if.rdata;
        if (m_ack) begin
          ack_cnt[p]++;
          checks++;
          if (grant !== p[0]) begin
            failures++;
            $display("FAIL ack_grant port%0d: got grant=%0b, required %0b", p, grant, p[0]);
          end
          checks++;
          if (exp_q[p].size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack port%0d: got ack, required none", p);
          end else begin
            m_e = exp_q[p].pop_front();
            if (m_e.we) begin
              if (ram_waddr !== m_e.addr || ram_data_in !== m_e.data || m_rd !== rd_track[p]) begin
                failures++;
                $display("FAIL write port%0d: got waddr=%h data=%h rdata=%h, required waddr=%h data=%h rdata=%h",
                         p, ram_waddr, ram_data_in, m_rd, m_e.addr, m_e.data, rd_track[p]);
              end
              waddr_track = m_e.addr;
            end else begin
              if (m_rd !== m_e.data || ram_raddr !== m_e.addr || ram_waddr !== waddr_track) begin
                failures++;
                $display("FAIL read port%0d: got rdata=%h raddr=%h waddr=%h, required rdata=%h raddr=%h waddr=%h",
                         p, m_rd, ram_raddr, ram_waddr, m_e.data, m_e.addr, waddr_track);
              end
              rd_track[p] = m_rd;
            end
          end
          checks++;
          if (m_rd_other !== rd_track[1-p]) begin
            failures++;
            $display("FAIL other_rdata port%0d: got %h, required %h", 1 - p, m_rd_other, rd_track[1-p]);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic issue(input int p, input bit we, input logic [8:0] addr, input logic [7:0] data);
    txn_t e;
    e.we   = we;
    e.addr = addr;
    if (we) begin
      e.data        = data;
      ref_mem[addr] = data;
    end else begin
      e.data = ref_mem[addr];
    end
    exp_q[p].push_back(e);
    if (p == 0) begin
      p0_if.req = 1'b1; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = data;
    end else begin
      p1_if.req = 1'b1; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = data;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) p0_if.req = 1'b0;
    else        p1_if.req = 1'b0;
  endtask

  // Waits (bounded) for this port's ack, then drops req after the ack cycle.
  task automatic wait_ack(input int p);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (p == 0) ? p0_if.ack : p1_if.ack;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ack_timeout port%0d: got no ack in 20 cycles, required ack", p);
    end
    @(posedge clk); #1;
    drop(p);
  endtask

  task automatic run_txn(input int p, input bit we, input logic [8:0] addr, input logic [7:0] data);
    issue(p, we, addr, data);
    wait_ack(p);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drop(0);
    drop(1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({p0_if.ack, p1_if.ack, ram_write, grant, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got ack0,ack1,ram_write,grant,busy=%b, required 00000",
               {p0_if.ack, p1_if.ack, ram_write, grant, busy});
    end
    checks++;
    if ({p0_if.rdata, p1_if.rdata, ram_raddr, ram_waddr, ram_data_in} !== '0) begin
      failures++;
      $display("FAIL reset_data: got rdata0=%h rdata1=%h raddr=%h waddr=%h din=%h, required all 0",
               p0_if.rdata, p1_if.rdata, ram_raddr, ram_waddr, ram_data_in);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_latency();
    issue(0, 1'b0, 9'h005, 8'h00);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (p0_if.ack !== (c == 3) || p1_if.ack !== 1'b0) begin
        failures++;
        $display("FAIL read_latency cycle%0d: got ack0=%b ack1=%b, required ack0=%b ack1=0",
                 c, p0_if.ack, p1_if.ack, (c == 3));
      end
    end
    checks++;
    if (p0_if.rdata !== 8'hA7) begin
      failures++;
      $display("FAIL read_data: got %h, required a7", p0_if.rdata);
    end
    @(posedge clk); #1;
    drop(0);
  endtask

  task automatic test_write_latency();
    issue(1, 1'b1, 9'h1FF, 8'h3C);
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (ram_write !== (c == 1) || p1_if.ack !== (c == 2)) begin
        failures++;
        $display("FAIL write_latency cycle%0d: got ram_write=%b ack1=%b, required %b %b",
                 c, ram_write, p1_if.ack, (c == 1), (c == 2));
      end
      if (c == 1) begin
        checks++;
        if (ram_waddr !== 9'h1FF || ram_data_in !== 8'h3C) begin
          failures++;
          $display("FAIL write_bus: got waddr=%h din=%h, required 1ff 3c", ram_waddr, ram_data_in);
        end
      end
    end
    @(posedge clk); #1;
    drop(1);
    run_txn(0, 1'b0, 9'h1FF, 8'h00);
    checks++;
    if (p0_if.rdata !== 8'h3C) begin
      failures++;
      $display("FAIL readback_1ff: got %h, required 3c", p0_if.rdata);
    end
  endtask

  task automatic test_arbitration();
    int rem [2];
    bit exp_g [4];
    int k = 0;
    int n [2] = '{0, 0};
    int base1;
    bit gp;
    apply_reset();
`ifdef MEM_ARB_FIXED_PRIO_EN
    rem   = '{4, 1};
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    rem   = '{2, 2};
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    base1 = ack_cnt[1];
    issue(0, 1'b1, 9'h040, 8'($urandom_range(0, 255)));
    issue(1, 1'b0, 9'h080, 8'h00);
    for (int cyc = 0; cyc < 80 && k < 4; cyc++) begin
      @(negedge clk);
      if (p0_if.ack || p1_if.ack) begin
        gp = p1_if.ack;
        checks++;
        if (grant !== exp_g[k]) begin
          failures++;
          $display("FAIL grant_seq[%0d]: got %0b, required %0b", k, grant, exp_g[k]);
        end
        k++;
        rem[gp]--;
        n[gp]++;
        @(posedge clk); #1;
        if (rem[gp] > 0) issue(int'(gp), !gp, (gp ? 9'h080 : 9'h040) + 9'(n[gp]), 8'($urandom_range(0, 255)));
        else             drop(int'(gp));
      end
    end
    checks++;
    if (k != 4) begin
      failures++;
      $display("FAIL grant_seq_count: got %0d acks, required 4", k);
    end
    drop(0);
    drop(1);
    exp_q[1].delete();
`ifdef MEM_ARB_FIXED_PRIO_EN
    checks++;
    if (ack_cnt[1] != base1) begin
      failures++;
      $display("FAIL fixed_prio_ack1: got %0d acks on port1, required 0", ack_cnt[1] - base1);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_late_drop();
    int base = ack_cnt[0];
    bit seen = 1'b0;
    issue(0, 1'b0, 9'h123, 8'h00);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = p0_if.ack;
    end
    checks++;
    if (!seen || busy !== 1'b1) begin
      failures++;
      $display("FAIL done_state: got ack0=%b busy=%b, required 1 1", seen, busy);
    end
    // req stays high through the whole ack cycle, dropped after that edge
    @(posedge clk); #1;
    drop(0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_done: got busy=%b, required 0", busy);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (ack_cnt[0] - base != 1) begin
      failures++;
      $display("FAIL single_txn: got %0d acks, required 1", ack_cnt[0] - base);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    issue(0, 1'b0, 9'h0AA, 8'h00);
    @(posedge clk);        // IDLE samples req -> RD_WAIT
    @(posedge clk); #1;    // now in RD_CAP
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || p0_if.ack !== 1'b0) begin
      failures++;
      $display("FAIL rd_cap_state: got busy=%b ack0=%b, required 1 0", busy, p0_if.ack);
    end
    @(negedge clk);
    checks++;
    if (p0_if.ack !== 1'b0 || p1_if.ack !== 1'b0 || busy !== 1'b0 || p0_if.rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: got ack0=%b ack1=%b busy=%b rdata0=%h, required 0 0 0 00",
               p0_if.ack, p1_if.ack, busy, p0_if.rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drop(0);
    exp_q[0].delete();
    run_txn(0, 1'b0, 9'h0AA, 8'h00);
  endtask

  task automatic test_boundary();
    for (int p = 0; p < 2; p++) begin
      run_txn(p, 1'b1, 9'h000, 8'($urandom_range(0, 255)));
      run_txn(p, 1'b1, 9'h1FF, 8'($urandom_range(0, 255)));
      run_txn(p, 1'b0, 9'h000, 8'h00);
      run_txn(p, 1'b0, 9'h1FF, 8'h00);
    end
    run_txn(0, 1'b0, 9'h000, 8'h00);
    run_txn(0, 1'b0, 9'h1FF, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    ram[5]     = 8'hA7;
    ref_mem[5] = 8'hA7;
    reset       = 1'b1;
    p0_if.req   = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
    p1_if.req   = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;

    test_reset();
    test_read_latency();
    test_write_latency();
    test_late_drop();
    test_reset_mid();
    test_boundary();
    test_arbitration();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
